// File: rtl/uc_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : uc_reg_loader
// Purpose  : uC serial frame receiver loading dynamic/static registers with
//            shadowed, BUSY-deferred commits.
// Revision : 1.0
// ============================================================================
module uc_reg_loader #(
    parameter int         SIZESRDYN  = 16,
    parameter int         SIZESRSTAT = 88,
    parameter logic [7:0] CMD_DYN    = 8'hD1,
    parameter logic [7:0] CMD_STAT   = 8'h5A
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  UC_SCK,
    input  logic                  UC_CS_N,
    input  logic                  UC_MOSI,
    input  logic                  BUSY,
    output logic [SIZESRDYN-1:0]  dynamicReg,
    output logic [SIZESRSTAT-1:0] staticReg,
    output logic                  DYN_UPD,
    output logic                  STAT_UPD,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN
);
    localparam int c_CNT_W = $clog2(SIZESRSTAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_cs_s1, r_cs_s2;
    logic r_mosi_s1, r_mosi_s2;
    logic r_armed;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [7:0]            r_cmd;
    logic                  r_is_stat;
    logic [SIZESRSTAT-1:0] r_shift;
    logic [SIZESRDYN-1:0]  r_dyn_shadow;
    logic [SIZESRSTAT-1:0] r_stat_shadow;
    logic                  r_dyn_pend, r_stat_pend;

    logic                  w_sck_rise;
    logic [7:0]            w_cmd_nxt;
    logic [SIZESRSTAT-1:0] w_shift_nxt;
    logic [c_CNT_W-1:0]    w_last_idx;
    logic                  w_start, w_cmd_dyn, w_cmd_stat;
    logic                  w_load_dyn, w_load_stat, w_frame_err;
    logic                  w_dyn_commit, w_stat_commit;

    assign w_sck_rise    = r_sck_s2 & ~r_sck_s3;
    assign w_cmd_nxt     = {r_cmd[6:0], r_mosi_s2};
    assign w_shift_nxt   = {r_shift[SIZESRSTAT-2:0], r_mosi_s2};
    assign w_last_idx    = r_is_stat ? c_CNT_W'(SIZESRSTAT - 1) : c_CNT_W'(SIZESRDYN - 1);
    assign w_dyn_commit  = r_dyn_pend & ~BUSY;
    assign w_stat_commit = r_stat_pend & ~BUSY;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cmd_dyn   = 1'b0;
        w_cmd_stat  = 1'b0;
        w_load_dyn  = 1'b0;
        w_load_stat = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_armed blocks a frame that was already running across reset
                if (!r_cs_s2 && r_armed) begin
                    w_state_nxt = S_CMD;
                    w_start     = 1'b1;
                end
            end
            S_CMD: begin
                if (r_cs_s2) begin
                    w_state_nxt = S_IDLE;
                    w_frame_err = 1'b1;
                end else if (w_sck_rise && r_bit_cnt == c_CNT_W'(7)) begin
                    if (w_cmd_nxt == CMD_DYN) begin
                        w_state_nxt = S_PAYLOAD;
                        w_cmd_dyn   = 1'b1;
                    end else if (w_cmd_nxt == CMD_STAT) begin
                        w_state_nxt = S_PAYLOAD;
                        w_cmd_stat  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_frame_err = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (r_cs_s2) begin
                    w_state_nxt = S_IDLE;
                    w_frame_err = 1'b1;
                end else if (w_sck_rise && r_bit_cnt == w_last_idx) begin
                    w_state_nxt = S_DONE;
                    w_load_dyn  = ~r_is_stat;
                    w_load_stat = r_is_stat;
                end
            end
            S_DONE: begin
                if (r_cs_s2) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sck_s1      <= 1'b0;
            r_sck_s2      <= 1'b0;
            r_sck_s3      <= 1'b0;
            r_cs_s1       <= 1'b0;
            r_cs_s2       <= 1'b0;
            r_mosi_s1     <= 1'b0;
            r_mosi_s2     <= 1'b0;
            r_armed       <= 1'b0;
            r_bit_cnt     <= '0;
            r_cmd         <= '0;
            r_is_stat     <= 1'b0;
            r_shift       <= '0;
            r_dyn_shadow  <= '0;
            r_stat_shadow <= '0;
            r_dyn_pend    <= 1'b0;
            r_stat_pend   <= 1'b0;
            dynamicReg    <= '0;
            staticReg     <= '0;
            DYN_UPD       <= 1'b0;
            STAT_UPD      <= 1'b0;
            FRAME_ERR     <= 1'b0;
            OVERRUN       <= 1'b0;
        end else begin
            r_sck_s1  <= UC_SCK;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_cs_s1   <= UC_CS_N;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= UC_MOSI;
            r_mosi_s2 <= r_mosi_s1;
            if (r_cs_s2) r_armed <= 1'b1;

            if (w_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_cmd_dyn || w_cmd_stat) begin
                r_bit_cnt <= '0;
                r_is_stat <= w_cmd_stat;
            end else if (w_sck_rise && (r_state == S_CMD || r_state == S_PAYLOAD)) begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
            if (w_sck_rise && r_state == S_CMD)     r_cmd   <= w_cmd_nxt;
            if (w_sck_rise && r_state == S_PAYLOAD) r_shift <= w_shift_nxt;

            // A new load wins over a same-cycle commit clearing the pending flag
            if (w_load_dyn) begin
                r_dyn_shadow <= w_shift_nxt[SIZESRDYN-1:0];
                r_dyn_pend   <= 1'b1;
            end else if (w_dyn_commit) begin
                r_dyn_pend   <= 1'b0;
            end
            if (w_load_stat) begin
                r_stat_shadow <= w_shift_nxt;
                r_stat_pend   <= 1'b1;
            end else if (w_stat_commit) begin
                r_stat_pend   <= 1'b0;
            end

            if (w_dyn_commit)  dynamicReg <= r_dyn_shadow;
            if (w_stat_commit) staticReg  <= r_stat_shadow;
            DYN_UPD   <= w_dyn_commit;
            STAT_UPD  <= w_stat_commit;
            FRAME_ERR <= w_frame_err;
            OVERRUN   <= (w_load_dyn & r_dyn_pend & BUSY) | (w_load_stat & r_stat_pend & BUSY);
        end
    end
endmodule
`default_nettype wire

// File: doc/uc_reg_loader.md
UC_REG_LOADER -- requirements
Module: uc_reg_loader

Interface
REQ-001 Parameter SIZESRDYN, default 16, dynamic register width.
REQ-002 Parameter SIZESRSTAT, default 88, static register width; SHALL be >= SIZESRDYN.
REQ-003 Parameter CMD_DYN, default 8'hD1, command byte selecting the dynamic target.
REQ-004 Parameter CMD_STAT, default 8'h5A, command byte selecting the static target.
REQ-005 CLK  in  1  system clock; all logic on rising edge.
REQ-006 RST_N  in  1  reset, synchronous, active-low.
REQ-007 UC_SCK  in  1  uC serial clock, asynchronous to CLK.
REQ-008 UC_CS_N  in  1  uC frame select, active-low, asynchronous.
REQ-009 UC_MOSI  in  1  uC serial data, asynchronous.
REQ-010 BUSY  in  1  high while downstream shift/latch sequence runs; commits are held off.
REQ-011 dynamicReg  out  SIZESRDYN  committed dynamic value.
REQ-012 staticReg  out  SIZESRSTAT  committed static value.
REQ-013 DYN_UPD  out  1  one-cycle pulse when dynamicReg changes.
REQ-014 STAT_UPD  out  1  one-cycle pulse when staticReg changes.
REQ-015 FRAME_ERR  out  1  one-cycle pulse on a bad or truncated frame.
REQ-016 OVERRUN  out  1  one-cycle pulse when a pending commit is overwritten.

Function
REQ-017 UC_SCK, UC_CS_N and UC_MOSI SHALL each pass through a 2-flop synchronizer; edge detection uses a third flop on SCK.
REQ-018 An SCK rise SHALL be the cycle in which synchronized SCK is 1 and its delayed copy is 0; MOSI (synchronized) is sampled in that cycle.
REQ-019 FSM states: IDLE, CMD, PAYLOAD, DONE.
REQ-020 IDLE -> CMD when synchronized CS_N is 0; bit counter cleared.
REQ-021 CMD: shift 8 bits MSB first; after the 8th, CMD_DYN -> PAYLOAD with length SIZESRDYN; CMD_STAT -> PAYLOAD with length SIZESRSTAT; any other byte -> DONE with FRAME_ERR pulse.
REQ-022 PAYLOAD: shift MSB first into one SIZESRSTAT-wide shift register; after the last bit the value (low bits for dynamic) SHALL be copied to that target's shadow register and its pending flag set the next cycle; state -> DONE.
REQ-023 DONE: further SCK rises ignored; -> IDLE when synchronized CS_N is 1.
REQ-024 CS_N high in CMD or PAYLOAD SHALL abort to IDLE, pulse FRAME_ERR, leave shadows and pending flags unchanged.
REQ-025 A pending target with BUSY=0 SHALL commit: output register loaded from shadow, UPD pulse, pending cleared, all in the same cycle.
REQ-026 Latency: last payload SCK rise detected in cycle N, BUSY=0 -> shadow/pending at N+1, output and UPD at N+2.
REQ-027 BUSY=1 SHALL hold commits; pending flags persist; commit occurs in the first cycle BUSY=0 is seen.
REQ-028 Both targets pending at BUSY release SHALL commit in the same cycle; DYN_UPD and STAT_UPD pulse together.
REQ-029 A completed frame to a target already pending SHALL overwrite its shadow and pulse OVERRUN; pending stays set.
REQ-030 Frames SHALL be accepted while BUSY=1; only the commit is deferred.
REQ-031 Outputs SHALL never change except via REQ-025 commits or reset.

Reset
REQ-032 RST_N=0 at a CLK edge SHALL set FSM to IDLE, counters, shift register, shadows, pending flags to 0.
REQ-033 Reset values: dynamicReg=0, staticReg=0, DYN_UPD=0, STAT_UPD=0, FRAME_ERR=0, OVERRUN=0.
REQ-034 Reset mid-frame SHALL discard the frame; after release, a frame already in progress (CS_N low) is treated as new only after CS_N goes high and then low again.

Verification
REQ-035 BUSY=0, frame D1 + 16'h1234 -> dynamicReg=16'h1234, one DYN_UPD pulse exactly 2 cycles after last SCK rise detected.
REQ-036 BUSY=1, frame 5A + 88'hABCDEF123456789ABCDEF1 -> staticReg unchanged while BUSY=1; on BUSY fall, staticReg=88'hABCDEF123456789ABCDEF1, one STAT_UPD pulse.
REQ-037 Command byte 8'h00 -> FRAME_ERR pulse, no UPD, outputs unchanged, next valid frame accepted.
REQ-038 CS_N raised after 10 payload bits of a D1 frame -> FRAME_ERR pulse, dynamicReg unchanged.
REQ-039 BUSY=1, frames D1+16'h1111 then D1+16'h2222 -> OVERRUN pulse; on BUSY fall dynamicReg=16'h2222, single DYN_UPD.
REQ-040 RST_N low during static payload bit 40 -> all outputs 0, no UPD after release until a new complete frame.
